// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the SYSREF-aligned ADC snapshot capture block.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        UNLOAD
    } state_e;

    localparam int SAMPLES_PER_BEAT = 8;
    localparam int LANE_BITS        = 16;
    localparam int BEAT_BITS        = 128;

endpackage

// File: rtl/adc_capture_ram.sv
// Simple dual-port record buffer: one write port, one registered read port.
module adc_capture_ram
    import adc_capture_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [BEAT_BITS-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [BEAT_BITS-1:0] rd_data
);

    logic [BEAT_BITS-1:0] mem [DEPTH];
    logic [BEAT_BITS-1:0] rd_data_q;

    // NOTE: the storage array and read register take no reset, so the array can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/adc_sysref_capture.sv
// Captures an NBEATS-beat ADC record on SYSREF rise or software trigger and unloads it one sample per beat.
// Optional ADC_SYSREF_CAPTURE_TIMESTAMP_EN adds a beat counter and the cap_time_o port.
module adc_sysref_capture
    import adc_capture_pkg::*;
#(
    parameter int NBEATS      = 64,
    parameter int SAMPLE_BITS = 12
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [BEAT_BITS-1:0]   s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   sysref_i,
    input  logic                   arm_i,
    input  logic                   sw_trig_i,
    output logic [SAMPLE_BITS-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   busy_o,
    output logic                   done_o
`ifdef ADC_SYSREF_CAPTURE_TIMESTAMP_EN
    ,
    output logic [31:0]            cap_time_o
`endif
);

    localparam int              AW        = $clog2(NBEATS);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(NBEATS - 1);

    logic [1:0]           rst_sync_q, rst_sync_d;
    logic                 rst_n;
    state_e               state_q, state_d;
    logic                 sysref_q, sysref_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic [AW-1:0]        fetch_addr_q, fetch_addr_d;
    logic                 fetch_done_q, fetch_done_d;
    logic                 pf_vld_q, pf_vld_d;
    logic                 pf_last_q, pf_last_d;
    logic [BEAT_BITS-1:0] beat_q, beat_d;
    logic                 beat_vld_q, beat_vld_d;
    logic                 beat_last_q, beat_last_d;
    logic [2:0]           lane_q, lane_d;
    logic                 done_q, done_d;

    logic                 trig, out_hs, lane_end, pf_load, wr_en, rd_en;
    logic [BEAT_BITS-1:0] rd_data;

    // Assertion is immediate; deassertion is released through two aclk flops.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_sync_q <= '0;
        else          rst_sync_q <= rst_sync_d;
    end
    assign rst_n = rst_sync_q[1];

    assign trig     = (sysref_i & ~sysref_q) | sw_trig_i;
    assign out_hs   = beat_vld_q & m_axis_tready;
    assign lane_end = out_hs & (lane_q == 3'd7);
    // The prefetched beat moves into the output register when it is empty or its lane 7 leaves.
    assign pf_load  = pf_vld_q & (~beat_vld_q | lane_end);

    // NOTE: always_comb uses blocking assignments with every output defaulted first, so no latch is inferred.
    always_comb begin
        rst_sync_d   = {rst_sync_q[0], 1'b1};
        state_d      = state_q;
        sysref_d     = sysref_i;
        wr_addr_d    = wr_addr_q;
        fetch_addr_d = fetch_addr_q;
        fetch_done_d = fetch_done_q;
        pf_vld_d     = pf_vld_q;
        pf_last_d    = pf_last_q;
        beat_d       = beat_q;
        beat_vld_d   = beat_vld_q;
        beat_last_d  = beat_last_q;
        lane_d       = lane_q;
        done_d       = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm_i) state_d = ARMED;
            end
            ARMED: begin
                if (trig) begin
                    state_d = CAPTURE;
                    if (s_axis_tvalid) begin
                        wr_en     = 1'b1;
                        wr_addr_d = wr_addr_q + AW'(1);
                    end
                end
            end
            CAPTURE: begin
                if (s_axis_tvalid) begin
                    wr_en = 1'b1;
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d   = UNLOAD;
                        wr_addr_d = '0;
                    end else begin
                        wr_addr_d = wr_addr_q + AW'(1);
                    end
                end
            end
            UNLOAD: begin
                if (!fetch_done_q && (!pf_vld_q || pf_load)) begin
                    rd_en        = 1'b1;
                    fetch_addr_d = fetch_addr_q + AW'(1);
                    fetch_done_d = (fetch_addr_q == LAST_ADDR);
                    pf_last_d    = (fetch_addr_q == LAST_ADDR);
                end
                pf_vld_d = rd_en | (pf_vld_q & ~pf_load);
                if (out_hs) lane_d = lane_q + 3'd1;
                if (pf_load) begin
                    beat_d      = rd_data;
                    beat_vld_d  = 1'b1;
                    beat_last_d = pf_last_q;
                    lane_d      = '0;
                end else if (lane_end) begin
                    beat_vld_d = 1'b0;
                end
                if (lane_end && beat_last_q) begin
                    state_d      = IDLE;
                    done_d       = 1'b1;
                    fetch_addr_d = '0;
                    fetch_done_d = 1'b0;
                    pf_vld_d     = 1'b0;
                    pf_last_d    = 1'b0;
                    beat_vld_d   = 1'b0;
                    beat_last_d  = 1'b0;
                    lane_d       = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sysref_q     <= 1'b0;
            wr_addr_q    <= '0;
            fetch_addr_q <= '0;
            fetch_done_q <= 1'b0;
            pf_vld_q     <= 1'b0;
            pf_last_q    <= 1'b0;
            beat_q       <= '0;
            beat_vld_q   <= 1'b0;
            beat_last_q  <= 1'b0;
            lane_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sysref_q     <= sysref_d;
            wr_addr_q    <= wr_addr_d;
            fetch_addr_q <= fetch_addr_d;
            fetch_done_q <= fetch_done_d;
            pf_vld_q     <= pf_vld_d;
            pf_last_q    <= pf_last_d;
            beat_q       <= beat_d;
            beat_vld_q   <= beat_vld_d;
            beat_last_q  <= beat_last_d;
            lane_q       <= lane_d;
            done_q       <= done_d;
        end
    end

    adc_capture_ram #(.DEPTH(NBEATS), .AW(AW)) u_ram (
        .clk     (aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr_q),
        .wr_data (s_axis_tdata),
        .rd_en   (rd_en),
        .rd_addr (fetch_addr_q),
        .rd_data (rd_data)
    );

    always_comb begin
        m_axis_tdata = beat_q[lane_q * LANE_BITS + (LANE_BITS - 1) -: SAMPLE_BITS];
    end

    assign s_axis_tready = rst_n;
    assign m_axis_tvalid = beat_vld_q;
    assign m_axis_tlast  = beat_vld_q & beat_last_q & (lane_q == 3'd7);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;

`ifdef ADC_SYSREF_CAPTURE_TIMESTAMP_EN
    logic [31:0] ts_cnt_q, ts_cnt_d;
    logic [31:0] cap_time_q, cap_time_d;

    always_comb begin
        ts_cnt_d   = ts_cnt_q + {31'd0, s_axis_tvalid & s_axis_tready};
        cap_time_d = ((state_q == ARMED) && trig) ? ts_cnt_q : cap_time_q;
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt_q   <= '0;
            cap_time_q <= '0;
        end else begin
            ts_cnt_q   <= ts_cnt_d;
            cap_time_q <= cap_time_d;
        end
    end

    assign cap_time_o = cap_time_q;
`endif

endmodule

// File: tb/tb_adc_sysref_capture.sv
// Directed self-checking bench for adc_sysref_capture (NBEATS=64, SAMPLE_BITS=12).
module tb_adc_sysref_capture;
    import adc_capture_pkg::*;

    localparam int NBEATS = 64;
    localparam int TOTAL  = NBEATS * SAMPLES_PER_BEAT;

    logic                 aclk = 1'b0;
    logic                 aresetn;
    logic [BEAT_BITS-1:0] s_axis_tdata;
    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic                 sysref_i;
    logic                 arm_i;
    logic                 sw_trig_i;
    logic [11:0]          m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;
    logic                 busy_o;
    logic                 done_o;
`ifdef ADC_SYSREF_CAPTURE_TIMESTAMP_EN
    logic [31:0]          cap_time_o;
`endif

    adc_sysref_capture #(.NBEATS(NBEATS), .SAMPLE_BITS(12)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .sysref_i      (sysref_i),
        .arm_i         (arm_i),
        .sw_trig_i     (sw_trig_i),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy_o        (busy_o),
        .done_o        (done_o)
`ifdef ADC_SYSREF_CAPTURE_TIMESTAMP_EN
        ,
        .cap_time_o    (cap_time_o)
`endif
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Results of the most recent record unload.
    int trig_cyc, first_cyc, last_cyc, got_n;
    int data_errs, last_errs, stall_errs, busy_errs, done_cnt;
    logic [11:0] sample3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BEAT_BITS-1:0] make_beat(input int idx);
        logic [BEAT_BITS-1:0] b;
        for (int k = 0; k < SAMPLES_PER_BEAT; k++) begin
            b[k*LANE_BITS +: LANE_BITS] = {8'(idx), 4'(k), 4'h0};
        end
        return b;
    endfunction

    function automatic logic [11:0] exp_sample(input int n);
        logic [7:0] b;
        logic [3:0] l;
        b = 8'(n / SAMPLES_PER_BEAT);
        l = 4'(n % SAMPLES_PER_BEAT);
        return {b, l};
    endfunction

    // Arm (with an ignored arm+trigger cycle and a repeated arm), trigger, then feed NBEATS beats.
    task automatic run_source(input bit use_sysref, input bit toggle, input int abort_at, input bit arm_in_unload);
        int n;
        int c;
        @(negedge aclk);
        arm_i = 1'b1; sw_trig_i = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = make_beat(8'hEE);
        @(negedge aclk);
        arm_i = 1'b0; sw_trig_i = 1'b0; s_axis_tvalid = 1'b0;
        @(negedge aclk);
        arm_i = 1'b1;
        @(negedge aclk);
        arm_i = 1'b0;
        @(negedge aclk);
        if (use_sysref) sysref_i = 1'b1;
        else            sw_trig_i = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = make_beat(0);
        trig_cyc = cyc;
        n = 1;
        c = 1;
        while (n < NBEATS) begin
            @(negedge aclk);
            if (abort_at >= 0 && n >= abort_at) return;
            sw_trig_i     = 1'b0;
            sysref_i      = use_sysref ? (c < 4) : (c == 5);
            s_axis_tvalid = toggle ? (c % 2 == 0) : 1'b1;
            if (s_axis_tvalid) begin
                s_axis_tdata = make_beat(n);
                n++;
            end
            c++;
        end
        for (int e = 0; e < 20; e++) begin
            @(negedge aclk);
            sw_trig_i     = 1'b0;
            sysref_i      = 1'b0;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = make_beat(NBEATS + e);
            arm_i         = arm_in_unload && (e == 15);
        end
        @(negedge aclk);
        arm_i         = 1'b0;
        s_axis_tvalid = 1'b0;
    endtask

    // Drain the record with the given tready duty and score every sample.
    task automatic run_sink(input int ready_pct);
        int waited = 0;
        int post   = 0;
        bit stalled = 1'b0;
        logic [11:0] held_d = '0;
        logic        held_l = 1'b0;
        got_n = 0; data_errs = 0; last_errs = 0; stall_errs = 0; busy_errs = 0; done_cnt = 0;
        first_cyc = -1; last_cyc = -1; sample3 = '0;
        while (waited < 6000 && !(got_n >= TOTAL && post >= 4)) begin
            @(negedge aclk);
            waited++;
            if (got_n >= TOTAL) post++;
            if (done_o) done_cnt++;
            if (m_axis_tvalid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (!busy_o) busy_errs++;
                if (stalled && (m_axis_tdata !== held_d || m_axis_tlast !== held_l)) stall_errs++;
            end else if (stalled) begin
                stall_errs++;
            end
            m_axis_tready = ($urandom_range(99) < ready_pct);
            if (m_axis_tvalid && m_axis_tready) begin
                if (got_n < TOTAL && m_axis_tdata !== exp_sample(got_n)) data_errs++;
                if (m_axis_tlast !== (got_n == TOTAL - 1)) last_errs++;
                if (got_n == 3) sample3 = m_axis_tdata;
                got_n++;
                last_cyc = cyc;
                stalled  = 1'b0;
            end else if (m_axis_tvalid) begin
                stalled = 1'b1;
                held_d  = m_axis_tdata;
                held_l  = m_axis_tlast;
            end
        end
        m_axis_tready = 1'b1;
    endtask

    task automatic check_record(input string tag, input int exp_latency);
        check({tag, "_count"},   got_n, TOTAL);
        check({tag, "_data"},    data_errs, 0);
        check({tag, "_tlast"},   last_errs, 0);
        check({tag, "_stall"},   stall_errs, 0);
        check({tag, "_busy"},    busy_errs, 0);
        check({tag, "_done"},    done_cnt, 1);
        check({tag, "_latency"}, first_cyc - trig_cyc, exp_latency);
    endtask

    initial begin
        int errs;
        aresetn = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0; sysref_i = 1'b0;
        arm_i = 1'b0; sw_trig_i = 1'b0; m_axis_tready = 1'b1;
        #2 aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tlast",  m_axis_tlast, 0);
        check("rst_m_tdata",  m_axis_tdata, 0);
        check("rst_busy",     busy_o, 0);
        check("rst_done",     done_o, 0);
`ifdef ADC_SYSREF_CAPTURE_TIMESTAMP_EN
        check("rst_cap_time", cap_time_o, 0);
`endif
        aresetn = 1'b1;
        repeat (4) @(negedge aclk);
        check("post_rst_tready", s_axis_tready, 1);

        // SYSREF edges and a software trigger while IDLE must not start anything.
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (busy_o || m_axis_tvalid) errs++;
            sysref_i = i[0]; sw_trig_i = (i == 7); s_axis_tvalid = 1'b1; s_axis_tdata = make_beat(i);
        end
        @(negedge aclk);
        sysref_i = 1'b0; sw_trig_i = 1'b0; s_axis_tvalid = 1'b0;
        repeat (2) @(negedge aclk);
        if (busy_o || m_axis_tvalid) errs++;
        check("idle_ignore", errs, 0);

        // Record A: sysref trigger, continuous beats, tready always high.
        fork
            run_source(1'b1, 1'b0, -1, 1'b0);
            run_sink(100);
        join
        check_record("recA", NBEATS + 2);
        check("recA_sample3", sample3, 12'h003);
        check("recA_throughput", last_cyc - first_cyc, TOTAL - 1);
        check("recA_idle_after", busy_o, 0);

        // Record B: software trigger, alternating tvalid, 30% tready, arm pulsed during unload.
        fork
            run_source(1'b0, 1'b1, -1, 1'b1);
            run_sink(30);
        join
        check_record("recB", 2 * NBEATS + 1);
        errs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge aclk);
            if (busy_o || m_axis_tvalid) errs++;
            sysref_i = (i % 4 == 1);
        end
        sysref_i = 1'b0;
        check("recB_arm_not_queued", errs, 0);

        // Reset in the middle of a capture, then a clean record.
        run_source(1'b0, 1'b0, 20, 1'b0);
        aresetn = 1'b0;
        #1;
        check("midrst_s_tready", s_axis_tready, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_outs", {m_axis_tvalid, m_axis_tlast, done_o, m_axis_tdata}, 0);
        repeat (3) @(negedge aclk);
        sw_trig_i = 1'b0; s_axis_tvalid = 1'b0;
        aresetn = 1'b1;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            if (busy_o || m_axis_tvalid || done_o) errs++;
        end
        check("midrst_quiet", errs, 0);
        check("midrst_tready", s_axis_tready, 1);
        fork
            run_source(1'b0, 1'b0, -1, 1'b0);
            run_sink(100);
        join
        check_record("recC", NBEATS + 2);

`ifdef ADC_SYSREF_CAPTURE_TIMESTAMP_EN
        // 1000 valid beats after reset, then a trigger: the trigger beat is stamped 1000.
        @(negedge aclk);
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        errs = 0;
        while (!s_axis_tready && errs < 20) begin
            @(negedge aclk);
            errs++;
        end
        check("ts_tready_wait", s_axis_tready, 1);
        for (int i = 0; i < 1000; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = make_beat(i);
            @(negedge aclk);
        end
        s_axis_tvalid = 1'b0;
        arm_i = 1'b1;
        @(negedge aclk);
        arm_i = 1'b0;
        @(negedge aclk);
        sw_trig_i = 1'b1; s_axis_tvalid = 1'b1;
        @(negedge aclk);
        sw_trig_i = 1'b0; s_axis_tvalid = 1'b0;
        check("ts_cap_time", cap_time_o, 1000);
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
